fp16_normalize_round: RTL and testbench

//  Post-add normalization/rounding stage for the 16-bit half-precision FPU.

---
 rtl/fp16_normalize_round_if.sv | 27 ++
 rtl/fp16_normalize_round.sv | 159 +++++++++++++++
 tb/tb_fp16_normalize_round.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fp16_normalize_round_if.sv
// Handshake and data bundle between the FPU sequencer and the fp16
// normalize/round stage.
//   master : sequencer side (drives start and the raw sum, watches status)
//   slave  : normalize/round stage
interface fp16_normalize_round_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    logic                   start;
    logic                   sign_in;
    logic [EXP_W-1:0]       exp_in;
    logic [MAN_W+3:0]       man_in;   // carry, hidden, fraction, guard, sticky
    logic                   busy;
    logic                   done;
    logic [EXP_W+MAN_W:0]   result;   // {sign, exp, frac}
    logic [1:0]             OFUF;     // 10 overflow, 01 underflow

    modport master (
        output start, sign_in, exp_in, man_in,
        input  busy, done, result, OFUF
    );

    modport slave (
        input  start, sign_in, exp_in, man_in,
        output busy, done, result, OFUF
    );
endinterface

// File: rtl/fp16_normalize_round.sv
// fp16_normalize_round: post-add normalization and rounding stage for the
// half-precision FPU. Takes the raw aligned sum (sign, biased exponent,
// extended mantissa with carry/hidden/guard/sticky) and produces a packed
// fp16 result plus overflow/underflow flags.
//
// Sequencing: IDLE -> NORM (one left shift per clock) -> ROUND -> DONE.
// Zero and underflow results skip ROUND. done is a one-cycle pulse; busy is
// high from the capture edge until the DONE state exits.
//
// Configuration macro: ROUND_NEAREST_EN
//   defined   : round-to-nearest-even in ROUND
//   undefined : truncate (guard/sticky ignored); ROUND still takes one cycle
//
// Denormals are never produced: anything that would need an exponent below
// 1 is flushed to a signed zero with the underflow flag set.
module fp16_normalize_round #(
    parameter int EXP_W = 5,    // only the default is supported
    parameter int MAN_W = 10    // only the default is supported
) (
    input  logic                  clk,
    input  logic                  reset,
    fp16_normalize_round_if.slave bus
);

    // Extended mantissa width: carry + hidden + fraction + guard + sticky.
    localparam int MW = MAN_W + 4;
    // One extra exponent bit so that an increment from all-ones cannot wrap.
    localparam int XW = EXP_W + 1;

    localparam logic [XW-1:0] EXP_ONE = XW'(1);
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic                   sgn;
    logic [XW-1:0]          exp_r;
    logic [MW-1:0]          man_r;
    logic                   busy_r;
    logic                   done_r;
    logic [EXP_W+MAN_W:0]   result_r;
    logic [1:0]             ofuf_r;

    logic                   round_up;
    logic [MW-1:0]          man_rnd;
    logic [XW-1:0]          exp_rnd;

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.OFUF   = ofuf_r;

    // Rounded mantissa/exponent as seen by the ROUND state. man_r[MW-2] is
    // set whenever ROUND is entered, so a carry out of the increment lands
    // exactly in the carry bit and is renormalized with a single right shift.
    always_comb begin
        round_up = 1'b0;
        man_rnd  = man_r;
        exp_rnd  = exp_r;
`ifdef ROUND_NEAREST_EN
        // Nearest-even: round up above the halfway point, or at exactly
        // halfway when the kept LSB is odd.
        round_up = man_r[1] & (man_r[0] | man_r[2]);
`else
        round_up = 1'b0;
`endif
        if (round_up) begin
            man_rnd = {man_r[MW-1:2] + (MW-2)'(1), man_r[1:0]};
        end
        if (man_rnd[MW-1]) begin
            man_rnd = {1'b0, man_rnd[MW-1:1]};
            exp_rnd = exp_r + XW'(1);
        end
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sgn      <= 1'b0;
            exp_r    <= '0;
            man_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            ofuf_r   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        sgn    <= bus.sign_in;
                        exp_r  <= {1'b0, bus.exp_in};
                        man_r  <= bus.man_in;
                        ofuf_r <= 2'b00;
                        busy_r <= 1'b1;
                        state  <= NORM;
                    end
                end

                NORM: begin
                    if (man_r == '0) begin
                        // Exact cancellation: always +0, sign dropped.
                        result_r <= '0;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end else if (man_r[MW-1]) begin
                        // Carry out of the add: shift right once and fold the
                        // bit falling off the end into sticky.
                        man_r <= {1'b0, man_r[MW-1:2], man_r[1] | man_r[0]};
                        exp_r <= exp_r + XW'(1);
                        state <= ROUND;
                    end else if (man_r[MW-2]) begin
                        state <= ROUND;
                    end else if (exp_r <= EXP_ONE) begin
                        // Further left shifts would need a denormal: flush.
                        result_r <= {sgn, (EXP_W + MAN_W)'(0)};
                        ofuf_r   <= 2'b01;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        man_r <= man_r << 1;
                        exp_r <= exp_r - XW'(1);
                    end
                end

                ROUND: begin
                    if (exp_rnd >= EXP_MAX) begin
                        result_r <= {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        ofuf_r   <= 2'b10;
                    end else begin
                        result_r <= {sgn, exp_rnd[EXP_W-1:0], man_rnd[MW-3:2]};
                    end
                    man_r  <= man_rnd;
                    exp_r  <= exp_rnd;
                    done_r <= 1'b1;
                    state  <= DONE;
                end

                DONE: begin
                    // start is deliberately not looked at here.
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_normalize_round.sv
// Directed bench for fp16_normalize_round: a vector table of raw sums with
// hand-computed results, flags and latencies, followed by hand-written
// sequences for reset abort, start-while-busy and start-on-DONE behaviour.
module tb_fp16_normalize_round;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp16_normalize_round_if bus ();

    fp16_normalize_round dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [13:0] m;
        logic [15:0] res;
        logic [1:0]  of;
        int          lat;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [4:0] e, input logic [13:0] m);
        bus.sign_in = s;
        bus.exp_in  = e;
        bus.man_in  = m;
    endtask

    // Counts rising edges (sampling 1 time unit after each) until done is
    // seen, giving up after 40.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        drive(v.s, v.e, v.m);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, " busy after capture"}, 32'(bus.busy), 32'd1);
        wait_done(lat);
        check({tag, " latency"}, 32'(lat), 32'(v.lat));
        check({tag, " result"}, 32'(bus.result), 32'(v.res));
        check({tag, " OFUF"}, 32'(bus.OFUF), 32'(v.of));
        @(posedge clk);
        #1;
        check({tag, " done one-shot"}, 32'(bus.done), 32'd0);
        check({tag, " busy released"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int lat;

        // Table: sign, exp, mantissa, result, OFUF, cycles from capture to done.
        vecs[0]  = '{1'b0, 5'd15, 14'b10_0000000000_00, 16'h4000, 2'b00, 2};
        vecs[1]  = '{1'b0, 5'd15, 14'b00_0000000001_00, 16'h1400, 2'b00, 12};
        vecs[2]  = '{1'b0, 5'd30, 14'b11_0000000000_00, 16'h7C00, 2'b10, 2};
        vecs[3]  = '{1'b1, 5'd30, 14'b11_0000000000_00, 16'hFC00, 2'b10, 2};
        vecs[4]  = '{1'b0, 5'd2,  14'b00_0010000000_00, 16'h0000, 2'b01, 2};
`ifdef ROUND_NEAREST_EN
        vecs[5]  = '{1'b0, 5'd15, 14'b01_1111111111_10, 16'h4000, 2'b00, 2};
        vecs[6]  = '{1'b0, 5'd15, 14'b01_0000000001_10, 16'h3C02, 2'b00, 2};
        vecs[7]  = '{1'b0, 5'd15, 14'b01_0000000000_11, 16'h3C01, 2'b00, 2};
`else
        vecs[5]  = '{1'b0, 5'd15, 14'b01_1111111111_10, 16'h3FFF, 2'b00, 2};
        vecs[6]  = '{1'b0, 5'd15, 14'b01_0000000001_10, 16'h3C01, 2'b00, 2};
        vecs[7]  = '{1'b0, 5'd15, 14'b01_0000000000_11, 16'h3C00, 2'b00, 2};
`endif
        // Zero sum: +0 regardless of sign, one cycle.
        vecs[8]  = '{1'b1, 5'd20, 14'b00_0000000000_00, 16'h0000, 2'b00, 1};
        // exp_in already at 31: overflow.
        vecs[9]  = '{1'b0, 5'd31, 14'b01_0000000000_00, 16'h7C00, 2'b10, 2};
        // Immediate underflow keeps the sign.
        vecs[10] = '{1'b1, 5'd1,  14'b00_1000000000_00, 16'h8000, 2'b01, 1};
        // Maximum shift count (k=11): only the guard bit set.
        vecs[11] = '{1'b0, 5'd20, 14'b00_0000000000_10, 16'h2400, 2'b00, 13};

        bus.start = 1'b0;
        drive(1'b0, 5'd0, 14'd0);
        reset = 1'b1;
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", 32'(bus.result), 32'h0);
        check("reset OFUF", 32'(bus.OFUF), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Carry input whose shifted-out bit becomes a halfway guard with an
        // even LSB: no rounding in either build.
        begin
            vec_t v;
            v = '{1'b0, 5'd15, 14'b11_0000000001_00, 16'h4200, 2'b00, 2};
            run_vec(v, "carry_tie");
        end

        // Start pulsed while busy must not disturb the running operation;
        // then start during DONE is ignored, start in the next IDLE accepted.
        @(negedge clk);
        drive(1'b0, 5'd15, 14'b00_0000000001_00);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = (lat == 2);
            if (lat == 2) drive(1'b0, 5'd15, 14'b10_0000000000_00);
            if (bus.done) break;
        end
        bus.start = 1'b0;
        check("busy_start latency", 32'(lat), 32'd12);
        check("busy_start result", 32'(bus.result), 32'h1400);

        drive(1'b0, 5'd30, 14'b11_0000000000_00);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("start on DONE ignored", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("start on first IDLE taken", 32'(bus.busy), 32'd1);
        wait_done(lat);
        check("post-DONE latency", 32'(lat), 32'd2);
        check("post-DONE result", 32'(bus.result), 32'h7C00);
        check("post-DONE OFUF", 32'(bus.OFUF), 32'd2);

        // Reset in the middle of a long normalization aborts at once.
        @(negedge clk);
        drive(1'b0, 5'd15, 14'b00_0000000001_00);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort result", 32'(bus.result), 32'h0);
        check("abort OFUF", 32'(bus.OFUF), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[0], "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
